// File: rtl/bcd_7seg_scanner.sv
// bcd_7seg_scanner
//   Time-multiplexed driver for a 4-digit common-anode 7-segment display.
//   One digit is selected at a time for DIGIT_PERIOD cycles. The first GUARD
//   cycles of each slot keep every anode off so the previous digit's segments
//   never ghost onto the next one. The input digits and masks are captured
//   once per frame, at the end of the digit-3 slot, so a value that changes
//   mid-scan is never shown half-old/half-new.
//
// Build option:
//   LEADING_ZERO_BLANK_EN - when defined, leading zero digits (3..1) are
//   suppressed. Digit 0 always shows. When undefined, only blank_in blanks.
//
// Parameters:
//   DIGIT_PERIOD  cycles per digit slot (>= GUARD+2)
//   GUARD         dark cycles at the start of each slot (< DIGIT_PERIOD)
//   CNT_WIDTH     slot counter width, must hold DIGIT_PERIOD-1
//
// Ports:
//   clk         system clock
//   clr         asynchronous active-high reset
//   en          scan enable; low = display dark, scan held at digit 0
//   bcd_in[k]   BCD digit k, k=0 is the rightmost digit
//   dp_in       per-digit decimal point request, active-high
//   blank_in    per-digit force-dark, active-high
//   an          anode selects, active-low, an[0] = rightmost digit
//   seg         segments {g,f,e,d,c,b,a}, active-low
//   dp          decimal point segment, active-low
//   frame_tick  one-cycle pulse as the scan wraps from digit 3 to digit 0

module bcd_7seg_scanner #(
  parameter int DIGIT_PERIOD = 100000,
  parameter int GUARD        = 1000,
  parameter int CNT_WIDTH    = 17
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  input  logic [3:0] bcd_in [3:0],
  input  logic [3:0] dp_in,
  input  logic [3:0] blank_in,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(DIGIT_PERIOD - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_GUARD = CNT_WIDTH'(GUARD);

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [3:0] AN_OFF   = 4'hF;

  // Active-low {g,f,e,d,c,b,a}; anything above 9 renders as a dash.
  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Scan state
  // ---------------------------------------------------------------------------
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [1:0]           r_idx;

  // Per-frame snapshot of the inputs; the pins only ever see these.
  logic [3:0][3:0]      r_snap_bcd;
  logic [3:0]           r_snap_dp;
  logic [3:0]           r_snap_blank;

  logic                 w_slot_end;
  logic                 w_frame_end;
  logic                 w_guard;
  logic                 w_snap_load;
  logic [3:0][6:0]      w_dec;
  logic [3:0]           w_blank;

  assign w_slot_end  = (r_cnt == CNT_LAST);
  assign w_frame_end = en && w_slot_end && (r_idx == 2'd3);
  assign w_guard     = (r_cnt < CNT_GUARD);
  // While disabled the snapshot tracks the inputs every cycle, so the first
  // frame after re-enable shows live data rather than whatever was frozen.
  assign w_snap_load = !en || w_frame_end;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (!en) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_slot_end) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_snap_bcd   <= '0;
      r_snap_dp    <= '0;
      r_snap_blank <= '0;
    end else if (w_snap_load) begin
      for (int k = 0; k < 4; k++) r_snap_bcd[k] <= bcd_in[k];
      r_snap_dp    <= dp_in;
      r_snap_blank <= blank_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-digit decode and blanking, selected by r_idx at the output stage
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < 4; k++) begin : g_dec
    assign w_dec[k] = decode(r_snap_bcd[k]);
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every digit above it are zero.
  // Digit 0 is never suppressed so a value of zero still shows "0".
  logic [3:0] w_lead_zero;
  assign w_lead_zero[3] = (r_snap_bcd[3] == 4'd0);
  assign w_lead_zero[2] = w_lead_zero[3] && (r_snap_bcd[2] == 4'd0);
  assign w_lead_zero[1] = w_lead_zero[2] && (r_snap_bcd[1] == 4'd0);
  assign w_lead_zero[0] = 1'b0;
  assign w_blank        = r_snap_blank | w_lead_zero;
`else
  assign w_blank        = r_snap_blank;
`endif

  // ---------------------------------------------------------------------------
  // Registered pin stage: one cycle behind the scan state.
  // A blanked digit still gets its anode so every slot has identical timing.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      an         <= AN_OFF;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= w_frame_end;
      if (!en || w_guard) begin
        an  <= AN_OFF;
        seg <= SEG_OFF;
        dp  <= 1'b1;
      end else begin
        an <= ~(4'b0001 << r_idx);
        if (w_blank[r_idx]) begin
          seg <= SEG_OFF;
          dp  <= 1'b1;
        end else begin
          seg <= w_dec[r_idx];
          dp  <= ~r_snap_dp[r_idx];
        end
      end
    end
  end

endmodule
